restoring_divider_unit: RTL and testbench

- Iterative unsigned restoring divider.
- Responder side of the go/done division handshake issued by the calculator system control unit.
- Samples dividend X and divisor Y on a go request and computes one quotient bit per clock.
- Returns quotient Q, remainder R, a done flag and a divide-by-zero flag.

---
 rtl/restoring_divider_unit.sv | 114 +++++++++++
 tb/tb_restoring_divider_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/restoring_divider_unit.sv
// Iterative unsigned restoring divider: one quotient bit per clock, answering
// a four-phase go/done request with quotient, remainder and a divide-by-zero flag.
module restoring_divider_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             done,
    output logic             busy,
    output logic             dz_flag,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic [1:0]       CS
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem, quo, div;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_sh, quo_sh, rem_step, quo_step;
    logic [WIDTH:0]   trial;
    logic             last_step;

    // Handshake: go is a level held by the initiator; a division starts only
    // when go is seen high in IDLE. done stays high while go stays high, and
    // the unit returns to IDLE only after go is seen low, so a held go never
    // restarts a second division.

    // rem < div always, so the shifted remainder never needs an extra bit.
    always_comb begin
        rem_sh    = {rem[WIDTH-2:0], quo[WIDTH-1]};
        quo_sh    = {quo[WIDTH-2:0], 1'b0};
        trial     = {1'b0, rem_sh} - {1'b0, div};
        rem_step  = trial[WIDTH] ? rem_sh : trial[WIDTH-1:0];
        quo_step  = {quo[WIDTH-2:0], ~trial[WIDTH]};
        last_step = (count == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go) state_nxt = (Y == '0) ? DONE : RUN;
            end
            RUN: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                if (!go) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem     <= '0;
            quo     <= '0;
            div     <= '0;
            count   <= '0;
            Q       <= '0;
            R       <= '0;
            dz_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        if (Y == '0) begin
                            Q       <= '1;
                            R       <= X;
                            dz_flag <= 1'b1;
                        end else begin
                            rem     <= '0;
                            quo     <= X;
                            div     <= Y;
                            count   <= CW'(WIDTH);
                            dz_flag <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem   <= rem_step;
                    quo   <= quo_step;
                    count <= count - CW'(1);
                    if (last_step) begin
                        Q <= quo_step;
                        R <= rem_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done = (state == DONE);
    assign busy = (state == RUN);
    assign CS   = state;

endmodule

// File: tb/tb_restoring_divider_unit.sv
// Self-checking bench for restoring_divider_unit: directed handshake cases,
// an exhaustive operand sweep and randomized runs against an arithmetic model.
module tb_restoring_divider_unit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         go;
    logic [W-1:0] X, Y;
    logic         done, busy, dz_flag;
    logic [W-1:0] Q, R;
    logic [1:0]   CS;

    int total = 0;
    int bad   = 0;

    restoring_divider_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .go(go), .X(X), .Y(Y),
        .done(done), .busy(busy), .dz_flag(dz_flag),
        .Q(Q), .R(R), .CS(CS)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer division; divide-by-zero returns all ones and R=X.
    function automatic void ref_div(input int x, input int y, output int q, output int r);
        if (y == 0) begin
            q = (1 << W) - 1;
            r = x;
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    // Issue one request, wait for done, check results and latency, hold go for
    // 'hold' extra cycles, then release go and check the return to IDLE.
    task automatic run_div(input int x, input int y, input int hold, input bit drop_early);
        int q, r, n, busy_n;
        ref_div(x, y, q, r);
        @(negedge clk);
        X  = x[W-1:0];
        Y  = y[W-1:0];
        go = 1'b1;
        @(posedge clk);
        n      = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            X = W'($urandom_range(0, (1 << W) - 1));
            Y = W'($urandom_range(0, (1 << W) - 1));
            if (drop_early && n == 1) go = 1'b0;
        end while (!done && n < 40);
        check("latency", n, (y == 0) ? 1 : W + 1);
        check("busy_cycles", busy_n, (y == 0) ? 0 : W);
        check("quotient", Q, q);
        check("remainder", R, r);
        check("dz_flag", dz_flag, (y == 0) ? 1 : 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_done", done, 1);
            check("hold_cs", CS, 2);
        end
        go = 1'b0;
        @(negedge clk);
        check("release_done", done, 0);
        check("release_cs", CS, 0);
    endtask

    initial begin
        rst = 1'b1;
        go  = 1'b0;
        X   = '0;
        Y   = '0;
        repeat (2) @(negedge clk);
        check("rst_cs", CS, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_dz", dz_flag, 0);
        check("rst_q", Q, 0);
        check("rst_r", R, 0);
        rst = 1'b0;

        run_div(13, 3, 10, 1'b0);
        run_div(15, 1, 0, 1'b0);
        run_div(2, 9, 0, 1'b0);
        run_div(7, 0, 0, 1'b0);
        run_div(9, 2, 0, 1'b0);
        run_div(11, 4, 0, 1'b1);

        // Reset on the second RUN edge of 14/3.
        @(negedge clk);
        X  = 4'd14;
        Y  = 4'd3;
        go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        go  = 1'b0;
        @(negedge clk);
        check("midrst_cs", CS, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_q", Q, 0);
        check("midrst_r", R, 0);
        rst = 1'b0;
        run_div(14, 3, 0, 1'b0);

        for (int x = 0; x < (1 << W); x++)
            for (int y = 0; y < (1 << W); y++)
                run_div(x, y, 0, 1'b0);

        repeat (40) begin
            bit de;
            de = 1'($urandom_range(0, 1));
            run_div($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1),
                    de ? 0 : $urandom_range(0, 3), de);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
